lfsr_param: RTL
===============

LFSR_PARAM -- requirements
Module: lfsr_param

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 3..32.
REQ-002 Parameter TAPS, default 8'hB8, WIDTH-bit feedback tap mask; bit i set means state bit i participates in feedback.
REQ-003 Parameter SEED, default 1, WIDTH-bit reset/fallback state; a value of 0 is illegal and SHALL be flagged at elaboration.
REQ-004 Parameter MODE, default 0, selects the structure: 0 = Fibonacci, 1 = Galois.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  advance one step per cycle while high.
REQ-008 load  input  1  load seed_in this cycle; takes priority over en.
REQ-009 seed_in  input  WIDTH  seed value captured on load.
REQ-010 q  output  WIDTH  current LFSR state, registered.
REQ-011 out_bit  output  1  serial output bit.
REQ-012 step_cnt  output  WIDTH  number of enabled steps since the last start point, registered.
REQ-013 wrap  output  1  one-cycle pulse when the state returns to the start value.
REQ-014 seed_err  output  1  one-cycle pulse when a zero seed is rejected.

Function
REQ-015 In Fibonacci mode, fb SHALL equal the XOR reduction of (q & TAPS), and the next state SHALL be {q[WIDTH-2:0], fb}.
REQ-016 In Fibonacci mode, out_bit SHALL equal q[WIDTH-1].
REQ-017 In Galois mode, the next state SHALL be {1'b0, q[WIDTH-1:1]} XOR ({WIDTH{q[0]}} & TAPS).
REQ-018 In Galois mode, out_bit SHALL equal q[0].
REQ-019 The block SHALL hold a start register equal to the state most recently set by reset or load.
REQ-020 On load with seed_in != 0, the block SHALL set q and start to seed_in, clear step_cnt to 0, and leave wrap low next cycle.
REQ-021 On load with seed_in == 0, the block SHALL set q and start to SEED, clear step_cnt, and pulse seed_err high for exactly one cycle; the all-zero lock-up state SHALL never be entered.
REQ-022 On en=1 and load=0, q SHALL advance one step with single-cycle latency, and step_cnt SHALL increment.
REQ-023 When the next state equals start, the block SHALL clear step_cnt to 0 instead of incrementing it and register wrap=1 for one cycle.
REQ-024 When en=0 and load=0, q, step_cnt and start SHALL hold, and wrap and seed_err SHALL be 0.
REQ-025 step_cnt arithmetic SHALL be modulo 2^WIDTH; it SHALL never exceed 2^WIDTH-1 for a maximal-length TAPS, and SHALL wrap silently for non-maximal TAPS.
REQ-026 When load and en are asserted together, load alone SHALL take effect and no step SHALL occur that cycle.
REQ-027 wrap and seed_err SHALL never be asserted in the same cycle.

Reset
REQ-028 While rst=0, the block SHALL force q=SEED, start=SEED, step_cnt=0, wrap=0 and seed_err=0 immediately, independent of clk.
REQ-029 On rst deassertion, the first enabled rising edge SHALL produce the step after SEED, and reset asserted mid-sequence SHALL abandon the sequence with no residual state.

Verification
REQ-030 WIDTH=4, TAPS=4'hC, MODE=0, SEED=1, rst released, en=1 -> q SHALL go 0001, 0010, 0100, 1001, 0011, 0110, 1101, and on the 15th step return to 0001 with wrap=1 for one cycle and step_cnt=0.
REQ-031 Same configuration, load=1 with seed_in=4'b1010 -> next cycle q=1010 and step_cnt=0; after 15 enabled steps q=1010 and wrap pulses.
REQ-032 load=1 with seed_in=0 -> q=SEED, seed_err=1 for one cycle, and q is nonzero on every subsequent cycle.
REQ-033 en toggled 1,0,0,1 -> q and step_cnt hold on the disabled cycles, and step_cnt ends at 2.
REQ-034 rst pulled low asynchronously mid-cycle after 7 steps -> q=0001 and step_cnt=0 before the next clk edge; the sequence restarts from 0001.
REQ-035 MODE=1, WIDTH=8, TAPS=8'hB8, SEED=1 -> exactly 255 distinct nonzero states before wrap, and load plus en in the same cycle loads without stepping.

Source files
------------

// File: rtl/lfsr_param_if.sv
// lfsr_param_if: control and status bundle between an LFSR user (master) and lfsr_param (slave)
interface lfsr_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] q;
  logic             out_bit;
  logic [WIDTH-1:0] step_cnt;
  logic             wrap;
  logic             seed_err;
  modport master (output en, load, seed_in, input q, out_bit, step_cnt, wrap, seed_err);
  modport slave  (input en, load, seed_in, output q, out_bit, step_cnt, wrap, seed_err);
endinterface

// File: rtl/lfsr_param.sv
// lfsr_param: Fibonacci/Galois LFSR with seed load, zero-seed guard, step counter and wrap pulse
module lfsr_param #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               MODE  = 0
) (
  input logic         clk,
  input logic         rst,
  lfsr_param_if.slave bus
);
  if (SEED == '0 || WIDTH < 3 || WIDTH > 32 || MODE < 0 || MODE > 1) begin : g_bad_param
    $error("lfsr_param: illegal parameters (zero SEED, WIDTH outside 3..32, or MODE not 0/1)");
  end
  logic [WIDTH-1:0] q_q, q_d, start_q, start_d, cnt_q, cnt_d, nxt, ld_val;
  logic             wrap_q, wrap_d, err_q, err_d, seed_ok;
  // a zero seed would lock the register, so it is replaced by SEED and reported
  always_comb begin
    nxt     = MODE == 1 ? {1'b0, q_q[WIDTH-1:1]} ^ ({WIDTH{q_q[0]}} & TAPS)
                        : {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    seed_ok = |bus.seed_in;
    ld_val  = seed_ok ? bus.seed_in : SEED;
    q_d     = bus.load ? ld_val : bus.en ? nxt : q_q;
    start_d = bus.load ? ld_val : start_q;
    wrap_d  = !bus.load && bus.en && nxt == start_q;
    cnt_d   = bus.load || wrap_d ? '0 : bus.en ? cnt_q + 1'b1 : cnt_q;
    err_d   = bus.load && !seed_ok;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q     <= SEED;
      start_q <= SEED;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end
  assign bus.q        = q_q;
  assign bus.out_bit  = MODE == 1 ? q_q[0] : q_q[WIDTH-1];
  assign bus.step_cnt = cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.seed_err = err_q;
endmodule
